gt_response_checker: RTL and testbench
======================================

Name: gt_response_checker

Overview:
- Self-checking response monitor: the receiving end of the greater-than comparator stimulus sequence.
- Accepts {A, B, F} vectors over a valid/ready handshake and computes the expected F = (A > B) internally.
- Counts vectors and mismatches, captures the first failing vector, and flags done/pass after a fixed number of vectors.
- Sits beside the greater-than comparator in the data-flow designs as a reusable hardware checker, so a bench no longer relies on waveform inspection.

Parameters:
- WIDTH, 2: operand width of A and B.
- NUM_VECTORS, 16: vectors per run; default is 2^(2*WIDTH), exhaustive coverage.
- CNT_W, 8: width of the vector and error counters; must be at least clog2(NUM_VECTORS+1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
- in_valid  input  1  sample valid.
- in_a  input  WIDTH  operand A as driven to the comparator.
- in_b  input  WIDTH  operand B as driven to the comparator.
- in_f  input  1  comparator output under test.
- in_ready  output  1  checker accepts a sample this cycle.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  high in DONE when err_count == 0.
- vec_count  output  CNT_W  samples accepted this run.
- err_count  output  CNT_W  mismatches this run; saturates at all-ones.
- first_err_valid  output  1  a mismatch has been captured this run.
- first_err_a  output  WIDTH  A of the first mismatch.
- first_err_b  output  WIDTH  B of the first mismatch.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low; the clock port is clk and the reset port is rst_n.
- Reset values: state = IDLE; every output is 0, including all counters and first_err fields.
- States and transitions:
  - IDLE: in_ready = 0. start -> RUN.
  - RUN: in_ready = 1, busy = 1. The accept that brings vec_count to NUM_VECTORS -> DONE.
  - DONE: done = 1; pass = (err_count == 0). start -> RUN.
- Entering RUN, on the clock edge that samples start: vec_count, err_count, first_err_valid, first_err_a and first_err_b clear to 0.
- Accept condition: in_valid && in_ready. Only registered outputs; no combinational path from inputs to outputs.
- On each accept:
  - expected = (in_a > in_b), unsigned compare.
  - vec_count increments.
  - If in_f != expected: err_count increments, saturating at 2^CNT_W-1.
  - If in_f != expected and first_err_valid == 0: capture in_a/in_b and set first_err_valid.
- Latency: counters and first_err fields update on the edge of the accept and are visible the next cycle. done/pass assert the cycle after the final accept.
- Boundary conditions:
  - start during RUN: ignored, counters are not cleared.
  - in_valid in IDLE or DONE: not accepted (in_ready = 0); no counter changes.
  - start and in_valid in the same cycle in IDLE: only start takes effect.
  - in_valid gaps in RUN: tolerated; nothing changes while idle.
  - rst_n low mid-run: immediate return to IDLE with all outputs cleared; the partial run is discarded.
  - NUM_VECTORS == 1: a single accept moves RUN -> DONE.
- Outputs remain stable in DONE until the next start or reset.

Optional Feature:
- Macro: GT_CHECK_ORDER_EN.
- Defined:
  - Adds output port order_err (1 bit, reset 0).
  - An internal expected index starts at 0 each run and increments per accept, modulo 2^(2*WIDTH).
  - An accepted {in_a, in_b} that differs from the index sets order_err (sticky until the next start or reset) and counts as a mismatch in err_count, even if in_f is correct. It is captured in first_err if it is the first mismatch.
  - pass additionally requires order_err == 0.
- Undefined: no order_err port and no ordering check; any vector order is accepted.

Test Plan:
- Reset, start, then {A,B} = 0..15 with F = (A>B), one per cycle -> done one cycle after the 16th accept; vec_count = 16, err_count = 0, pass = 1, first_err_valid = 0.
- Same sequence with F inverted only at {A,B} = 4'd5 (A=1, B=1, F driven 1) -> err_count = 1, pass = 0, first_err_valid = 1, first_err_a = 1, first_err_b = 1.
- All 16 F values inverted -> err_count = 16, first_err_a = 0, first_err_b = 0, pass = 0.
- in_valid toggled 1/0 every cycle, plus a start pulse mid-run -> still done after exactly 16 accepts; counters are not cleared by the mid-run start.
- rst_n pulsed low after 7 accepts -> outputs 0 asynchronously and state IDLE; a new start with 16 correct vectors gives pass = 1.
- GT_CHECK_ORDER_EN defined: correct F but vectors 2 and 3 swapped -> order_err = 1, err_count = 2, first_err_a = 0, first_err_b = 3, pass = 0.

Source files
------------

// File: rtl/gt_response_checker.sv
// Response checker for a greater-than comparator: accepts {A,B,F} samples, counts mismatches
// against F = (A > B) and reports done/pass after NUM_VECTORS samples. Optional GT_CHECK_ORDER_EN adds an ordering check.
module gt_response_checker #(
  parameter int WIDTH       = 2,
  parameter int NUM_VECTORS = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_f,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
`ifdef GT_CHECK_ORDER_EN
  output logic             order_err,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake: a sample is taken on any rising edge where in_valid && in_ready;
  // in_ready is registered and high only while in RUN, so it never depends on in_valid.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t             state;
  logic               accept;
  logic               expected;
  logic               order_hit;
  logic               order_next;
  logic               mismatch;
  logic [CNT_W-1:0]   err_next;

  assign dbg_state = state;

`ifdef GT_CHECK_ORDER_EN
  localparam logic [2*WIDTH-1:0] IDX_ONE = (2*WIDTH)'(1);
  logic [2*WIDTH-1:0] exp_idx;
  assign order_hit  = ({in_a, in_b} != exp_idx);
  assign order_next = order_err | order_hit;
`else
  assign order_hit  = 1'b0;
  assign order_next = 1'b0;
`endif

  always_comb begin
    accept   = in_valid && in_ready;
    expected = (in_a > in_b);
    mismatch = (in_f != expected) || order_hit;
    err_next = err_count;
    if (mismatch && (err_count != CNT_MAX)) err_next = err_count + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      in_ready        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
`ifdef GT_CHECK_ORDER_EN
      exp_idx         <= '0;
      order_err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= RUN;
            in_ready        <= 1'b1;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            vec_count       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
`ifdef GT_CHECK_ORDER_EN
            exp_idx         <= '0;
            order_err       <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (accept) begin
            vec_count <= vec_count + CNT_ONE;
            err_count <= err_next;
            if (mismatch && !first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_a     <= in_a;
              first_err_b     <= in_b;
            end
`ifdef GT_CHECK_ORDER_EN
            exp_idx   <= exp_idx + IDX_ONE;
            order_err <= order_next;
`endif
            // Final sample: pass uses the post-update error state.
            if (vec_count == LAST_IDX) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              pass     <= (err_next == '0) && !order_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gt_response_checker.sv
// Bench for gt_response_checker: directed and random runs scored against a run-level reference model.
module tb_gt_response_checker;
  localparam int WIDTH = 2;
  localparam int NV    = 16;
  localparam int CNT_W = 8;
  localparam int VW    = 2 * WIDTH + 1;
  localparam int EW    = 2 * CNT_W + 2 * WIDTH + 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_f = 1'b0;
  logic             in_ready, busy, done, pass, first_err_valid;
  logic [CNT_W-1:0] vec_count, err_count;
  logic [WIDTH-1:0] first_err_a, first_err_b;
  logic [1:0]       dbg_state;
  logic             order_bit;

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] vec_q[$];
  logic [EW-1:0] exp_q[$];

  gt_response_checker #(.WIDTH(WIDTH), .NUM_VECTORS(NV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_f(in_f),
    .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_a(first_err_a), .first_err_b(first_err_b),
`ifdef GT_CHECK_ORDER_EN
    .order_err(order_bit),
`endif
    .dbg_state(dbg_state)
  );

`ifndef GT_CHECK_ORDER_EN
  assign order_bit = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] result_word();
    return {pass, vec_count, err_count, first_err_valid, first_err_a, first_err_b, order_bit};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // reference model: outcome of a whole run computed from the vector list
  function automatic logic [EW-1:0] model();
    int errs = 0;
    logic fev = 1'b0;
    logic [WIDTH-1:0] fa = '0, fb = '0;
    logic oe = 1'b0;
    logic ok;
    foreach (vec_q[i]) begin
      logic [VW-1:0] v;
      int a, b;
      logic bad;
      v = vec_q[i];
      a = int'(v[VW-1 -: WIDTH]);
      b = int'(v[WIDTH:1]);
      bad = (v[0] != (a > b));
`ifdef GT_CHECK_ORDER_EN
      if (a * (1 << WIDTH) + b != i % (1 << (2 * WIDTH))) begin
        bad = 1'b1;
        oe = 1'b1;
      end
`endif
      if (bad) begin
        errs++;
        if (!fev) begin
          fev = 1'b1;
          fa = WIDTH'(a);
          fb = WIDTH'(b);
        end
      end
    end
    ok = (errs == 0);
    if (errs > 255) errs = 255;
    return {ok, CNT_W'(vec_q.size()), CNT_W'(errs), fev, fa, fb, oe};
  endfunction

  // stimulus builders: mode 0 correct, 1 wrong F at index 5, 2 all F wrong, 3 swap 2/3, 4 random
  task automatic build(input int mode);
    vec_q.delete();
    for (int i = 0; i < NV; i++) begin
      int a, b;
      logic f;
      a = (i >> WIDTH) % (1 << WIDTH);
      b = i % (1 << WIDTH);
      if (mode == 3 && i == 2) b = 3;
      if (mode == 3 && i == 3) b = 2;
      if (mode == 4) begin
        a = $urandom_range(0, (1 << WIDTH) - 1);
        b = $urandom_range(0, (1 << WIDTH) - 1);
      end
      f = (a > b);
      if (mode == 2 || (mode == 1 && i == 5)) f = ~f;
      if (mode == 4 && $urandom_range(0, 4) == 0) f = ~f;
      vec_q.push_back({WIDTH'(a), WIDTH'(b), f});
    end
  endtask

  // driver: gap 0 none, 1 toggle, 2 random; abort_after >= 0 resets mid-run
  task automatic run(input int gap, input bit mid_start, input int abort_after);
    int i = 0;
    int cyc = 0;
    int t = 0;
    logic [VW-1:0] v;
    if (abort_after < 0) exp_q.push_back(model());
    start = 1'b1;
    in_valid = 1'b1;
    in_a = WIDTH'($urandom);
    in_b = WIDTH'($urandom);
    in_f = 1'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    while (i < vec_q.size() && !(abort_after >= 0 && i == abort_after)) begin
      logic vld;
      vld = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      in_valid = vld;
      v = vld ? vec_q[i] : VW'($urandom);
      {in_a, in_b, in_f} = v;
      start = mid_start && (cyc == 6);
      @(posedge clk); #1;
      if (vld) i++;
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (abort_after >= 0) begin
      check("count_before_reset", 64'(vec_count), 64'(abort_after));
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", 64'({in_ready, busy, done, result_word()}), 64'(0));
      check("async_reset_state", 64'(dbg_state), 64'(0));
      #2 rst_n = 1'b1;
    end else begin
      while (!done && t < 4) begin
        @(posedge clk); #1;
        t++;
      end
      check("done_latency", 64'(t), 64'(0));
      in_valid = 1'b1;
      repeat (2) begin
        {in_a, in_b, in_f} = VW'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("done_hold", 64'({done, in_ready, busy}), 64'(3'b100));
      check("done_no_accept", 64'(vec_count), 64'(vec_q.size()));
    end
  endtask

  // monitor: scores each completed run on the rising edge of done
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev <= 1'b0;
    end else begin
      done_prev <= done;
      if (done && !done_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon_unexpected_done: got %0h expected none", result_word());
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          if (result_word() !== e) begin
            errors++;
            $display("FAIL mon_result: got %0h expected %0h", result_word(), e);
          end
        end
      end
    end
  end

  initial begin
    #3;
    check("reset_outputs", 64'({in_ready, busy, done, result_word()}), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(0));
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    repeat (2) begin
      {in_a, in_b, in_f} = VW'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("idle_no_accept", 64'({in_ready, vec_count}), 64'(0));

    build(0); run(0, 1'b0, -1);
    build(1); run(0, 1'b0, -1);
    build(2); run(0, 1'b0, -1);
    build(0); run(1, 1'b1, -1);
    build(0); run(0, 1'b0, 7);
    build(0); run(0, 1'b0, -1);
    build(3); run(0, 1'b0, -1);
    for (int k = 0; k < 6; k++) begin
      build(4);
      run(2, k[0], -1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
